// File: rtl/asm_mem_stream_dma_pkg.sv
// rtl/asm_mem_stream_dma_pkg.sv - shared types and default widths for the memory stream DMA
// Purpose: FSM state type and default parameter values used by the DMA top.
// Ports: none (package).
package asm_mem_stream_dma_pkg;

  localparam int DEF_DATAWIDTH  = 128;
  localparam int DEF_ADDRWIDTH  = 14;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_DRAIN = 2'd3
  } dma_state_t;

endpackage

// File: rtl/asm_sync_fifo.sv
// rtl/asm_sync_fifo.sv - synchronous FIFO with occupancy count
// Purpose: buffers read-return words between the memory port and the read stream.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointers and count only)
//   push, wdata  write side
//   pop, rdata   read side, rdata is the current head
//   count, empty occupancy
module asm_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/asm_mem_stream_dma.sv
// rtl/asm_mem_stream_dma.sv - burst DMA between the memory mux in2 port and valid/ready streams
// Purpose: turns {dir, base, len} commands into sequential word accesses. Reads flow
//   memory -> return FIFO -> rd stream; writes flow wr stream -> memory.
// Ports:
//   clk_i, reset_n_i                   clock, async active-low reset
//   cmd_start_i/write/addr/len         burst command, start sampled only while idle
//   busy_o, done_o                     burst status, one-cycle completion pulse
//   rd_valid_o/rd_data_o/rd_ready_i    read stream out
//   wr_valid_i/wr_data_i/wr_ready_o    write stream in
//   mem_en/wben/addr/wdata/rdata/stall memory mux in2 port
module asm_mem_stream_dma
  import asm_mem_stream_dma_pkg::*;
#(
  parameter int MEM_DATAWIDTH = DEF_DATAWIDTH,
  parameter int MEM_ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int MEM_BSELWIDTH = MEM_DATAWIDTH / 8,
  parameter int LEN_WIDTH     = MEM_ADDRWIDTH + 1,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cmd_start_i,
  input  logic                     cmd_write_i,
  input  logic [MEM_ADDRWIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]     cmd_len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     rd_valid_o,
  output logic [MEM_DATAWIDTH-1:0] rd_data_o,
  input  logic                     rd_ready_i,
  input  logic                     wr_valid_i,
  input  logic [MEM_DATAWIDTH-1:0] wr_data_i,
  output logic                     wr_ready_o,
  output logic                     mem_en_o,
  output logic [MEM_BSELWIDTH-1:0] mem_wben_o,
  output logic [MEM_ADDRWIDTH-1:0] mem_addr_o,
  output logic [MEM_DATAWIDTH-1:0] mem_wdata_o,
  input  logic [MEM_DATAWIDTH-1:0] mem_rdata_i,
  input  logic                     mem_stall_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_t               state;
  dma_state_t               state_nxt;
  logic [MEM_ADDRWIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]     remaining;
  logic                     inflight;
  logic                     done_q;
  logic [CW-1:0]            fifo_count;
  logic [MEM_DATAWIDTH-1:0] fifo_head;
  logic                     fifo_empty;
  logic                     start_ok;
  logic                     accept;
  logic                     credit_ok;
  logic                     last_word;
  logic                     rd_pop;
  logic                     last_pop;

  // done_q covers the completion cycle of writes and zero-length bursts, where
  // the FSM is already back in IDLE but the burst still counts as busy.
  assign busy_o    = (state != ST_IDLE) | done_q;
  assign start_ok  = cmd_start_i & ~busy_o;
  // Words already requested but not yet popped must leave room in the FIFO,
  // so a read is only issued while FIFO_DEPTH - count - inflight > 0.
  assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
  assign last_word = (remaining == LEN_WIDTH'(1));
  assign accept    = mem_en_o & ~mem_stall_i;

  assign rd_valid_o = ~fifo_empty;
  assign rd_data_o  = fifo_empty ? '0 : fifo_head;
  assign rd_pop     = rd_valid_o & rd_ready_i;
  assign last_pop   = (state == ST_DRAIN) & ~inflight & (fifo_count == CW'(1)) & rd_pop;
  assign done_o     = done_q | last_pop;
  assign mem_addr_o = addr;

  always_comb begin
    state_nxt   = state;
    mem_en_o    = 1'b0;
    mem_wben_o  = '0;
    mem_wdata_o = '0;
    wr_ready_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok && (cmd_len_i != '0)) state_nxt = cmd_write_i ? ST_WR : ST_RD;
      end
      ST_RD: begin
        mem_en_o = (remaining != '0) & credit_ok;
        if (mem_en_o && !mem_stall_i && last_word) state_nxt = ST_DRAIN;
      end
      ST_WR: begin
        mem_en_o    = wr_valid_i;
        mem_wben_o  = '1;
        mem_wdata_o = wr_data_i;
        wr_ready_o  = wr_valid_i & ~mem_stall_i;
        if (wr_valid_i && !mem_stall_i && last_word) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (last_pop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= (state == ST_RD) & accept;
      done_q   <= (start_ok & (cmd_len_i == '0)) | ((state == ST_WR) & accept & last_word);
      if (start_ok) begin
        addr      <= cmd_addr_i;
        remaining <= cmd_len_i;
      end else if (accept) begin
        addr      <= addr + MEM_ADDRWIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  // Read data arrives one cycle after acceptance, exactly when inflight is set.
  asm_sync_fifo #(
    .WIDTH (MEM_DATAWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .push  (inflight),
    .wdata (mem_rdata_i),
    .pop   (rd_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
